// File: rtl/timing_beat_gen_if.sv
// Control handshake between the beat generator and the main decoder.
// Inputs flow slave-ward; beat/cycle timing flows back to the master.
interface timing_beat_gen_if;
  logic START;
  logic STOP;
  logic G;
  logic SKIP4;
  logic SSTEP;
  logic QD;
  logic T1;
  logic T2;
  logic T3;
  logic T4;
  logic W1;
  logic W2;
  logic P;
  logic RUN;

  modport master (
    output START, STOP, G, SKIP4, SSTEP, QD,
    input  T1, T2, T3, T4, W1, W2, P, RUN
  );

  modport slave (
    input  START, STOP, G, SKIP4, SSTEP, QD,
    output T1, T2, T3, T4, W1, W2, P, RUN
  );
endinterface

// File: rtl/timing_beat_gen.sv
// Machine-cycle (W1/W2) and one-hot beat (T1..T4) sequencer
// with run/halt, operator stop, single-step and beat divider.
module timing_beat_gen #(
  parameter int DIV_W = 4,
  parameter int DIV   = 0
) (
  input logic CLK,
  input logic CLRN,
  timing_beat_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV);

  state_t           state_q, state_d;
  logic [3:0]       beat_q, beat_d;
  logic             w_q, w_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       qd_q;
  logic             qd_rise;
  logic             p;
  logic             cyc_end;

  // W register holds 1 for W2 so reset lands on W1.
  assign p       = (state_q == RUN) && (div_q == DIV_MAX);
  assign cyc_end = beat_q[3] | (beat_q[2] & bus.SKIP4);
  assign qd_rise = qd_q[1] & ~qd_q[2];

  // Two-flop synchronizer plus a delay flop for edge detect.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) qd_q <= '0;
    else       qd_q <= {qd_q[1:0], bus.QD};
  end

  // Sequencer state register.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q <= IDLE;
      beat_q  <= '0;
      w_q     <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      w_q     <= w_d;
      div_q   <= div_d;
    end
  end

  // Next-state: beats move only on strobe clocks; halt
  // requests outrank stop, which outranks single-step.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    w_d     = w_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (bus.START) begin
          state_d = RUN;
          beat_d  = 4'b0001;
          w_d     = 1'b0;
        end
      end
      RUN: begin
        if (!p) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          priority case (1'b1)
            bus.G: begin
              state_d = IDLE;
              beat_d  = '0;
              w_d     = 1'b0;
            end
            cyc_end && bus.STOP: begin
              state_d = IDLE;
              beat_d  = '0;
              w_d     = ~w_q;
            end
            cyc_end && bus.SSTEP: begin
              state_d = PAUSE;
              beat_d  = '0;
              w_d     = ~w_q;
            end
            cyc_end: begin
              beat_d = 4'b0001;
              w_d    = ~w_q;
            end
            default: beat_d = beat_q << 1;
          endcase
        end
      end
      PAUSE: begin
        div_d = '0;
        if (bus.STOP) begin
          state_d = IDLE;
        end else if (qd_rise) begin
          state_d = RUN;
          beat_d  = 4'b0001;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        w_d     = 1'b0;
        div_d   = '0;
      end
    endcase
  end

  assign bus.T1  = (state_q == RUN) & beat_q[0];
  assign bus.T2  = (state_q == RUN) & beat_q[1];
  assign bus.T3  = (state_q == RUN) & beat_q[2];
  assign bus.T4  = (state_q == RUN) & beat_q[3];
  assign bus.W1  = ~w_q;
  assign bus.W2  = w_q;
  assign bus.P   = p;
  assign bus.RUN = (state_q == RUN);

endmodule

// File: tb/tb_timing_beat_gen.sv
// Directed bench for timing_beat_gen at DIV=0 and DIV=2.
// Outputs packed as {RUN,P,W2,W1,T4,T3,T2,T1}.
module tb_timing_beat_gen;

  logic CLK = 1'b0;
  logic CLRN;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  timing_beat_gen_if a_if ();
  timing_beat_gen_if b_if ();

  timing_beat_gen #(.DIV_W(4), .DIV(0)) dut_a (
    .CLK  (CLK),
    .CLRN (CLRN),
    .bus  (a_if.slave)
  );

  timing_beat_gen #(.DIV_W(4), .DIV(2)) dut_b (
    .CLK  (CLK),
    .CLRN (CLRN),
    .bus  (b_if.slave)
  );

  function automatic logic [7:0] ex(logic run, logic p,
                                    logic w2, logic [3:0] t);
    return {run, p, w2, ~w2, t};
  endfunction

  function automatic logic [7:0] oa();
    return {a_if.RUN, a_if.P, a_if.W2, a_if.W1,
            a_if.T4, a_if.T3, a_if.T2, a_if.T1};
  endfunction

  function automatic logic [7:0] ob();
    return {b_if.RUN, b_if.P, b_if.W2, b_if.W1,
            b_if.T4, b_if.T3, b_if.T2, b_if.T1};
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    CLRN = 1'b0;
    {a_if.START, a_if.STOP, a_if.G} = '0;
    {a_if.SKIP4, a_if.SSTEP, a_if.QD} = '0;
    {b_if.START, b_if.STOP, b_if.G} = '0;
    {b_if.SKIP4, b_if.SSTEP, b_if.QD} = '0;
    #3;
    chk("reset_a", oa(), ex(0, 0, 0, 4'b0000));
    chk("reset_b", ob(), ex(0, 0, 0, 4'b0000));
    @(negedge CLK);
    CLRN = 1'b1;
    tick();
    chk("idle_a", oa(), ex(0, 0, 0, 4'b0000));

    // DIV=0 free run through W1, W2, back to W1
    a_if.START = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      a_if.START = 1'b0;
      chk($sformatf("run_a%0d", i), oa(),
          ex(1, 1, ((i / 4) % 2) == 1, 4'b0001 << (i % 4)));
    end

    // G on the W2 T1 strobe clock
    a_if.G = 1'b1;
    tick();
    a_if.G = 1'b0;
    chk("g_halt", oa(), ex(0, 0, 0, 4'b0000));
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    chk("g_restart", oa(), ex(1, 1, 0, 4'b0001));

    // single-step
    a_if.SSTEP = 1'b1;
    tick(); tick();
    tick();
    chk("ss_t4", oa(), ex(1, 1, 0, 4'b1000));
    tick();
    chk("ss_pause", oa(), ex(0, 0, 1, 4'b0000));
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    chk("ss_start_ign", oa(), ex(0, 0, 1, 4'b0000));
    a_if.QD = 1'b1;
    tick();
    chk("qd_lat1", oa(), ex(0, 0, 1, 4'b0000));
    tick();
    chk("qd_lat2", oa(), ex(0, 0, 1, 4'b0000));
    tick();
    chk("qd_w2t1", oa(), ex(1, 1, 1, 4'b0001));
    tick(); tick(); tick();
    chk("ss_w2t4", oa(), ex(1, 1, 1, 4'b1000));
    tick();
    chk("ss_pause2", oa(), ex(0, 0, 0, 4'b0000));
    tick(); tick(); tick();
    chk("qd_held", oa(), ex(0, 0, 0, 4'b0000));
    a_if.SSTEP = 1'b0;
    a_if.QD = 1'b0;

    // STOP in PAUSE -> IDLE, then START must work
    a_if.STOP = 1'b1;
    tick();
    a_if.STOP = 1'b0;
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    chk("stop_p_start", oa(), ex(1, 1, 0, 4'b0001));

    // STOP raised at W1 T2
    tick();
    chk("stop_t2", oa(), ex(1, 1, 0, 4'b0010));
    a_if.STOP = 1'b1;
    tick();
    chk("stop_t3", oa(), ex(1, 1, 0, 4'b0100));
    tick();
    chk("stop_t4", oa(), ex(1, 1, 0, 4'b1000));
    tick();
    a_if.STOP = 1'b0;
    chk("stop_idle", oa(), ex(0, 0, 1, 4'b0000));
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    chk("stop_restart", oa(), ex(1, 1, 0, 4'b0001));

    // G and STOP together at cycle end -> W1
    tick(); tick(); tick();
    a_if.G = 1'b1;
    a_if.STOP = 1'b1;
    tick();
    a_if.G = 1'b0;
    a_if.STOP = 1'b0;
    chk("g_stop", oa(), ex(0, 0, 0, 4'b0000));

    // async reset during W2 T3
    a_if.START = 1'b1;
    tick();
    a_if.START = 1'b0;
    repeat (6) tick();
    chk("pre_rst", oa(), ex(1, 1, 1, 4'b0100));
    CLRN = 1'b0;
    #1;
    chk("async_rst", oa(), ex(0, 0, 0, 4'b0000));
    #1;
    CLRN = 1'b1;

    // DIV=2 with SKIP4 during W1 T3
    b_if.SKIP4 = 1'b1;
    b_if.START = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      b_if.START = 1'b0;
      if (i < 9)
        chk($sformatf("div_b%0d", i), ob(),
            ex(1, (i % 3) == 2, 0, 4'b0001 << (i / 3)));
      else
        chk($sformatf("div_b%0d", i), ob(),
            ex(1, (i % 3) == 2, 1, 4'b0001));
    end
    b_if.SKIP4 = 1'b0;
    tick();
    chk("b_w2t2_d0", ob(), ex(1, 0, 1, 4'b0010));
    b_if.G = 1'b1;
    tick();
    b_if.G = 1'b0;
    chk("b_g_ign", ob(), ex(1, 0, 1, 4'b0010));
    tick();
    chk("b_w2t2_p", ob(), ex(1, 1, 1, 4'b0010));
    tick();
    chk("b_w2t3", ob(), ex(1, 0, 1, 4'b0100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

endmodule
